// File: rtl/deshiphrator.sv
// deshiphrator: iterative Kuznyechik (GOST R 34.12-2015) block decryptor.
// Sixteen R^-1 byte steps form one L^-1, followed by S^-1 and a round-key XOR.
module deshiphrator (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic [127:0] input_word,
    input  logic [127:0] key_1,
    input  logic [127:0] key_2,
    input  logic [127:0] key_3,
    input  logic [127:0] key_4,
    input  logic [127:0] key_5,
    input  logic [127:0] key_6,
    input  logic [127:0] key_7,
    input  logic [127:0] key_8,
    input  logic [127:0] key_9,
    input  logic [127:0] key_10,
    output logic [127:0] output_word,
    output logic         finish,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, LIN, SUB, DONE} fsm_t;

    localparam logic [0:255][7:0] PI = {
        128'hFCEEDD11CF6E3116FBC4FADA23C5044D, 128'hE977F0DB932E99BA1736F1BB14CD5FC1,
        128'hF918655AE25CEF21811C3C428B018E4F, 128'h058402AEE36A8FA0060BED987FD4D31F,
        128'hEB342C51EAC848ABF22A68A2FD3ACECC, 128'hB5700E56080C7612BF7213479CB75D87,
        128'h15A19629107B9AC7F391786F9D9EB2B1, 128'h3275193DFF358A7E6D54C680C3BD0D57,
        128'hDFF524A93EA843C9D779D6F67C22B903, 128'hE00FECDE7A94B0BCDCE828504E330A4A,
        128'hA79760731E0062441AB83882649F2641, 128'hAD454692275E552F8CA3A57D69D5953B,
        128'h0758B34086AC1DF730376BE488D9E789, 128'hE11B83494C3FF8FE8D53AA90CAD88561,
        128'h207167A42D2B095BCB9B25D0BEE56C52, 128'h59A674D2E6F4B4C0D166AFC2394B63B6
    };
    localparam logic [15:0][7:0] LC = {
        8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
        8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
    };

    // The inverse S-box ROM is derived from pi at elaboration so only one table is maintained.
    function automatic logic [0:255][7:0] invert_pi();
        logic [0:255][7:0] r;
        r = '0;
        for (int i = 0; i < 256; i++) r[PI[i]] = i[7:0];
        return r;
    endfunction
    localparam logic [0:255][7:0] PI_INV = invert_pi();

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'hC3) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [127:0] r_inv(input logic [127:0] a);
        logic [127:0] b;
        logic [7:0]   l;
        b = {a[119:0], a[127:120]};
        l = '0;
        for (int k = 0; k < 16; k++) l = l ^ gf_mul(b[k*8 +: 8], LC[k]);
        return {a[119:0], l};
    endfunction

    function automatic logic [127:0] s_inv(input logic [127:0] a);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[k*8 +: 8] = PI_INV[a[k*8 +: 8]];
        return r;
    endfunction

    fsm_t          fsm_q, fsm_d;
    logic [127:0]  state_q, state_d, out_q, out_d;
    logic [3:0]    round_q, round_d, step_q, step_d;
    logic          finish_q, finish_d, busy_q, busy_d;
    logic [9:1][127:0] round_keys;

    assign round_keys  = {key_9, key_8, key_7, key_6, key_5, key_4, key_3, key_2, key_1};
    assign output_word = out_q;
    assign finish      = finish_q;
    assign busy        = busy_q;

    always_comb begin
        fsm_d    = fsm_q;
        state_d  = state_q;
        round_d  = round_q;
        step_d   = step_q;
        out_d    = out_q;
        finish_d = finish_q;
        busy_d   = busy_q;
        case (fsm_q)
            IDLE: begin
                finish_d = 1'b0;
                if (enable) begin
                    state_d = input_word ^ key_10;
                    round_d = 4'd9;
                    step_d  = 4'd0;
                    busy_d  = 1'b1;
                    fsm_d   = LIN;
                end
            end
            LIN: begin
                state_d = r_inv(state_q);
                step_d  = step_q + 4'd1;
                fsm_d   = (step_q == 4'd15) ? SUB : LIN;
            end
            SUB: begin
                state_d = s_inv(state_q) ^ round_keys[round_q];
                fsm_d   = (round_q == 4'd1) ? DONE : LIN;
                round_d = (round_q == 4'd1) ? round_q : round_q - 4'd1;
            end
            DONE: begin
                out_d    = state_q;
                finish_d = 1'b1;
                busy_d   = 1'b0;
                fsm_d    = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q    <= IDLE;
            state_q  <= '0;
            round_q  <= '0;
            step_q   <= '0;
            out_q    <= '0;
            finish_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            state_q  <= state_d;
            round_q  <= round_d;
            step_q   <= step_d;
            out_q    <= out_d;
            finish_q <= finish_d;
            busy_q   <= busy_d;
        end
    end
endmodule
